reg_cmd_master: RTL and testbench

- Command-side initiator for the register file: drives WrEn/RdEn/Address/WrData and captures RdData.
- Receives byte-serial command frames, typically from a UART receiver, and issues one register access per frame.
- Returns read data as a byte stream through a valid/ready handshake toward a transmitter.
- Sits between the serial front-end and the register file in the system controller.

---
 rtl/reg_cmd_master.sv | 147 ++++++++++++++
 tb/tb_reg_cmd_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_master.sv
// Byte-serial command master: parses write/read frames and drives one register-file access per frame.
// Optional build macro REG_CMD_ADDR_CHECK_EN aborts frames whose address byte has bits above ADDR_WIDTH set.
module reg_cmd_master #(
  parameter int         REG_WIDTH  = 16,
  parameter int         ADDR_WIDTH = 3,
  parameter logic [7:0] WR_CMD     = 8'hAA,
  parameter logic [7:0] RD_CMD     = 8'hBB
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_Data,
  input  logic                  RX_Valid,
  input  logic [REG_WIDTH-1:0]  RdData,
  input  logic                  TX_Ready,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [REG_WIDTH-1:0]  WrData,
  output logic [7:0]            TX_Data,
  output logic                  TX_Valid,
  output logic                  Busy,
  output logic                  Cmd_Err,
  output logic                  Overrun
);

  localparam int NB    = REG_WIDTH / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_WDATA, WRITE, READ_REQ, READ_WAIT, SEND
  } state_t;

  state_t               state, next_state;
  logic                 wr_flag;
  logic [CNT_W-1:0]     byte_cnt;
  logic [REG_WIDTH-1:0] tx_shift;
  logic                 last_byte, tx_fire, addr_bad, cmd_err_d, overrun_d;

  // byte_cnt is shared: it counts write-data bytes in GET_WDATA and sent bytes in SEND.
  assign last_byte = (byte_cnt == CNT_W'(NB - 1));
  assign tx_fire   = TX_Valid && TX_Ready;

`ifdef REG_CMD_ADDR_CHECK_EN
  assign addr_bad = (ADDR_WIDTH < 8) && ((RX_Data >> ADDR_WIDTH) != 8'd0);
`else
  assign addr_bad = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    cmd_err_d  = 1'b0;
    overrun_d  = 1'b0;
    unique case (state)
      IDLE: if (RX_Valid) begin
        if (RX_Data == WR_CMD || RX_Data == RD_CMD) next_state = GET_ADDR;
        else                                         cmd_err_d  = 1'b1;
      end
      GET_ADDR: if (RX_Valid) begin
        if (addr_bad) begin
          next_state = IDLE;
          cmd_err_d  = 1'b1;
        end else begin
          next_state = wr_flag ? GET_WDATA : READ_REQ;
        end
      end
      GET_WDATA: if (RX_Valid && last_byte) next_state = WRITE;
      WRITE: begin
        next_state = IDLE;
        overrun_d  = RX_Valid;
      end
      READ_REQ: begin
        next_state = READ_WAIT;
        overrun_d  = RX_Valid;
      end
      READ_WAIT: begin
        next_state = SEND;
        overrun_d  = RX_Valid;
      end
      SEND: begin
        overrun_d = RX_Valid;
        if (tx_fire && last_byte) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes are decoded from next_state so they are registered yet line up with the state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      Address  <= '0;
      WrData   <= '0;
      TX_Data  <= '0;
      TX_Valid <= 1'b0;
      Busy     <= 1'b0;
      Cmd_Err  <= 1'b0;
      Overrun  <= 1'b0;
      wr_flag  <= 1'b0;
      byte_cnt <= '0;
      tx_shift <= '0;
    end else begin
      WrEn    <= (next_state == WRITE);
      RdEn    <= (next_state == READ_REQ);
      Busy    <= (next_state != IDLE);
      Cmd_Err <= cmd_err_d;
      Overrun <= overrun_d;
      unique case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (RX_Valid) wr_flag <= (RX_Data == WR_CMD);
        end
        GET_ADDR: if (RX_Valid && !addr_bad) Address <= RX_Data[ADDR_WIDTH-1:0];
        GET_WDATA: if (RX_Valid) begin
          for (int k = 0; k < NB; k++)
            if (byte_cnt == CNT_W'(k)) WrData[8*k +: 8] <= RX_Data;
          byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
        end
        READ_WAIT: begin
          TX_Data  <= RdData[7:0];
          tx_shift <= RdData >> 8;
          TX_Valid <= 1'b1;
          byte_cnt <= '0;
        end
        SEND: if (tx_fire) begin
          if (last_byte) begin
            TX_Valid <= 1'b0;
            byte_cnt <= '0;
          end else begin
            TX_Data  <= tx_shift[7:0];
            tx_shift <= tx_shift >> 8;
            byte_cnt <= byte_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_master.sv
// Directed self-checking bench for reg_cmd_master (16-bit registers, 3-bit address) with a register file model.
module tb_reg_cmd_master;

  localparam int RW = 16;
  localparam int AW = 3;

  logic          CLK, RST;
  logic [7:0]    RX_Data;
  logic          RX_Valid;
  logic [RW-1:0] RdData;
  logic          TX_Ready;
  logic          WrEn, RdEn;
  logic [AW-1:0] Address;
  logic [RW-1:0] WrData;
  logic [7:0]    TX_Data;
  logic          TX_Valid, Busy, Cmd_Err, Overrun;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0, rd_pulses = 0, err_pulses = 0, ovr_pulses = 0;
  bit both_seen = 1'b0;
  logic [RW-1:0] regs [8];

  reg_cmd_master #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .RX_Data(RX_Data), .RX_Valid(RX_Valid), .RdData(RdData),
    .TX_Ready(TX_Ready), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .TX_Data(TX_Data), .TX_Valid(TX_Valid), .Busy(Busy), .Cmd_Err(Cmd_Err), .Overrun(Overrun)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Register file: writes on WrEn, read data valid the cycle after RdEn.
  always @(posedge CLK) begin
    if (WrEn) regs[Address] <= WrData;
    if (RdEn) RdData <= regs[Address];
  end

  always @(negedge CLK) begin
    if (WrEn)         wr_pulses++;
    if (RdEn)         rd_pulses++;
    if (Cmd_Err)      err_pulses++;
    if (Overrun)      ovr_pulses++;
    if (WrEn && RdEn) both_seen = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {WrEn, RdEn, TX_Valid, Busy, Cmd_Err, Overrun}, 32'd0);
    check({tag, "_addr"}, Address, 32'd0);
    check({tag, "_wdata"}, WrData, 32'd0);
    check({tag, "_txdata"}, TX_Data, 32'd0);
  endtask

  // Called at a negedge; returns at the next negedge with the byte consumed.
  task automatic send_byte(input logic [7:0] b);
    RX_Data  = b;
    RX_Valid = 1'b1;
    @(negedge CLK);
    RX_Valid = 1'b0;
  endtask

  task automatic recv_bytes(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    int n = 0;
    TX_Ready = 1'b1;
    while (!TX_Valid && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_valid0"}, TX_Valid, 32'd1);
    check({tag, "_byte0"}, TX_Data, b0);
    @(negedge CLK);
    check({tag, "_valid1"}, TX_Valid, 32'd1);
    check({tag, "_byte1"}, TX_Data, b1);
    @(negedge CLK);
    check({tag, "_done_valid"}, TX_Valid, 32'd0);
    check({tag, "_done_busy"}, Busy, 32'd0);
    TX_Ready = 1'b0;
  endtask

  initial begin
    RST = 1'b1; RX_Valid = 1'b0; RX_Data = 8'h00; TX_Ready = 1'b0;
    #1 RST = 1'b0;
    #1 check_all_zero("por");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("por_busy", Busy, 32'd0);

    // Write AA,05,07,00
    send_byte(8'hAA);
    check("wr_busy_after_cmd", Busy, 32'd1);
    send_byte(8'h05);
    send_byte(8'h07);
    check("wr_no_early_wren", WrEn, 32'd0);
    send_byte(8'h00);
    check("wr_wren", WrEn, 32'd1);
    check("wr_addr", Address, 32'd5);
    check("wr_data", WrData, 32'h0007);
    check("wr_rden", RdEn, 32'd0);
    @(negedge CLK);
    check("wr_wren_drop", WrEn, 32'd0);
    check("wr_idle_busy", Busy, 32'd0);

    // Write 000F to 7, then read it back under backpressure
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h0F); send_byte(8'h00);
    check("wr2_wren", WrEn, 32'd1);
    @(negedge CLK);
    send_byte(8'hBB);
    send_byte(8'h07);
    check("rd_rden", RdEn, 32'd1);
    check("rd_addr", Address, 32'd7);
    check("rd_no_wren", WrEn, 32'd0);
    @(negedge CLK);
    check("rd_rden_drop", RdEn, 32'd0);
    @(negedge CLK);
    check("bp_valid", TX_Valid, 32'd1);
    check("bp_byte0", TX_Data, 32'h0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("bp_hold_valid", TX_Valid, 32'd1);
      check("bp_hold_byte", TX_Data, 32'h0F);
    end
    TX_Ready = 1'b1;
    @(negedge CLK);
    check("bp_byte1_valid", TX_Valid, 32'd1);
    check("bp_byte1", TX_Data, 32'h00);
    @(negedge CLK);
    check("bp_end_valid", TX_Valid, 32'd0);
    check("bp_end_busy", Busy, 32'd0);
    TX_Ready = 1'b0;

    // Illegal command, then a clean read of register 5
    send_byte(8'h3C);
    check("ill_cmd_err", Cmd_Err, 32'd1);
    check("ill_busy", Busy, 32'd0);
    check("ill_strobes", {WrEn, RdEn}, 32'd0);
    @(negedge CLK);
    check("ill_cmd_err_drop", Cmd_Err, 32'd0);
    send_byte(8'hBB); send_byte(8'h05);
    recv_bytes("ill_rd", 8'h07, 8'h00);

    // Overrun during SEND
    send_byte(8'hBB); send_byte(8'h05);
    repeat (2) @(negedge CLK);
    check("ovr_in_send", TX_Valid, 32'd1);
    send_byte(8'h55);
    check("ovr_pulse", Overrun, 32'd1);
    check("ovr_tx_hold", TX_Data, 32'h07);
    @(negedge CLK);
    check("ovr_pulse_drop", Overrun, 32'd0);
    check("ovr_still_busy", Busy, 32'd1);
    recv_bytes("ovr_rd", 8'h07, 8'h00);

    // Asynchronous reset mid-SEND
    send_byte(8'hBB); send_byte(8'h07);
    repeat (2) @(negedge CLK);
    check("rst_in_send", TX_Valid, 32'd1);
    #2 RST = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_release_busy", Busy, 32'd0);
    check("rst_release_valid", TX_Valid, 32'd0);

    // Address byte with upper bits set
    send_byte(8'hAA);
    send_byte(8'h0D);
`ifdef REG_CMD_ADDR_CHECK_EN
    check("opt_addr_err", Cmd_Err, 32'd1);
    check("opt_addr_idle", Busy, 32'd0);
    send_byte(8'h11);
    check("opt_d0_err", Cmd_Err, 32'd1);
    send_byte(8'h22);
    check("opt_d1_err", Cmd_Err, 32'd1);
    check("opt_no_wren", WrEn, 32'd0);
`else
    check("opt_addr_no_err", Cmd_Err, 32'd0);
    check("opt_addr_busy", Busy, 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    check("opt_wren", WrEn, 32'd1);
    check("opt_addr", Address, 32'd5);
    check("opt_wdata", WrData, 32'h2211);
`endif
    repeat (3) @(negedge CLK);

`ifdef REG_CMD_ADDR_CHECK_EN
    check("tot_wr_pulses", wr_pulses, 32'd2);
    check("tot_err_pulses", err_pulses, 32'd4);
`else
    check("tot_wr_pulses", wr_pulses, 32'd3);
    check("tot_err_pulses", err_pulses, 32'd1);
`endif
    check("tot_rd_pulses", rd_pulses, 32'd4);
    check("tot_ovr_pulses", ovr_pulses, 32'd1);
    check("never_both", both_seen, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
